// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM state encoding shared by seq_alu
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    localparam int F_S = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: one-step-per-cycle shift/rotate and shift-add multiply datapath with step counter
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             hi_nz_o,
    output logic             done_o
);

    localparam int SHW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] data_q, data_d, hi_q, hi_d, mc_q, mc_d;
    logic [WIDTH-1:0] d_s, hi_s, mc_s, d_st, hi_st;
    logic [SHW-1:0]   cnt_q, cnt_d, n;
    logic [3:0]       op_q, op_d, op_s;
    logic             c_q, c_d, c_st;
    logic [WIDTH:0]   sum;

    // Step count, step operands (fresh inputs on the start cycle so the accept edge already does step one) and one step
    always_comb begin
        if (op_i == OP_MUL)
            n = SHW'(WIDTH);
        else if (op_i == OP_SLR)
            n = {1'b0, b_i[SHW-2:0]};
        else
            n = (|b_i[WIDTH-1:SHW-1]) ? SHW'(WIDTH) : b_i[SHW-1:0];
        op_s = start_i ? op_i : op_q;
        d_s  = start_i ? ((op_i == OP_MUL) ? b_i : a_i) : data_q;
        hi_s = start_i ? '0 : hi_q;
        mc_s = start_i ? a_i : mc_q;
        sum  = {1'b0, hi_s} + (d_s[0] ? {1'b0, mc_s} : '0);
        hi_st = hi_s;
        case (op_s)
            OP_SLL: {c_st, d_st} = {d_s, 1'b0};
            OP_SLR: {c_st, d_st} = {d_s[WIDTH-1], d_s[WIDTH-2:0], d_s[WIDTH-1]};
            OP_SRL: {d_st, c_st} = {1'b0, d_s};
            OP_SRA: {d_st, c_st} = {d_s[WIDTH-1], d_s};
            default: begin
                d_st  = {sum[0], d_s[WIDTH-1:1]};
                hi_st = sum[WIDTH:1];
                c_st  = 1'b0;
            end
        endcase
    end

    // Next-state: load on start, then step and count down until the counter reaches zero
    always_comb begin
        op_d   = op_s;
        mc_d   = mc_s;
        data_d = data_q;
        hi_d   = hi_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        done_o = 1'b0;
        if (start_i) begin
            if (n == '0) begin
                data_d = a_i;
                hi_d   = '0;
                c_d    = 1'b0;
                cnt_d  = '0;
                done_o = 1'b1;
            end else begin
                data_d = d_st;
                hi_d   = hi_st;
                c_d    = c_st;
                cnt_d  = n - SHW'(1);
                done_o = (n == SHW'(1));
            end
        end else if (cnt_q != '0) begin
            data_d = d_st;
            hi_d   = hi_st;
            c_d    = c_st;
            cnt_d  = cnt_q - SHW'(1);
            done_o = (cnt_q == SHW'(1));
        end
    end

    assign res_o   = data_d;
    assign carry_o = c_d;
    assign hi_nz_o = |hi_d;

    // Datapath and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            hi_q   <= '0;
            mc_q   <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
        end else begin
            data_q <= data_d;
            hi_q   <= hi_d;
            mc_q   <= mc_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshake, registered result and flags
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       salu,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aout,
    output logic [3:0]       fout,
    output logic             out_err
);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d, op_c, fout_q, fout_d;
    logic [WIDTH-1:0] aout_q, aout_d, s_r, res_r, it_res;
    logic [WIDTH:0]   sum, diff;
    logic             err_q, err_d, s_c, s_v, s_err, res_c, res_v, res_err;
    logic             mul_c, iter_c, start, commit, it_c, it_hinz, it_done;

    assign op_c   = (state_q == IDLE) ? salu : op_q;
    assign mul_c  = (op_c == OP_MUL);
    assign iter_c = mul_c || (op_c[3:2] == 2'b10);
    assign start  = (state_q == IDLE) && in_valid && iter_c;
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .op_i    (salu),
        .a_i     (a),
        .b_i     (b),
        .res_o   (it_res),
        .carry_o (it_c),
        .hi_nz_o (it_hinz),
        .done_o  (it_done)
    );

    // Single-cycle ops; anything neither single-cycle nor iterative is illegal
    always_comb begin
        s_r   = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_err = 1'b0;
        case (salu)
            OP_ADD: begin
                s_r = sum[WIDTH-1:0];
                s_c = sum[WIDTH];
                s_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_r = diff[WIDTH-1:0];
                s_c = diff[WIDTH];
                s_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  s_r = a & b;
            OP_OR:   s_r = a | b;
            OP_XOR:  s_r = a ^ b;
            default: s_err = !iter_c;
        endcase
    end

    // Result selection, FSM next state and result capture on the edge entering DONE
    always_comb begin
        res_r   = iter_c ? it_res : s_r;
        res_c   = iter_c ? (mul_c ? it_hinz : it_c) : s_c;
        res_v   = iter_c ? (mul_c && it_hinz) : s_v;
        res_err = !iter_c && s_err;
        state_d = state_q;
        op_d    = op_q;
        aout_d  = aout_q;
        fout_d  = fout_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = salu;
                commit  = !iter_c || it_done;
                state_d = commit ? DONE : EXEC;
            end
            EXEC: begin
                commit  = it_done;
                state_d = it_done ? DONE : EXEC;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (commit) begin
            aout_d      = res_r;
            fout_d[F_S] = res_r[WIDTH-1];
            fout_d[F_Z] = (res_r == '0);
            fout_d[F_C] = res_c;
            fout_d[F_V] = res_v;
            err_d       = res_err;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            aout_q  <= '0;
            fout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            aout_q  <= aout_d;
            fout_q  <= fout_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign aout      = aout_q;
    assign fout      = fout_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector self-checking bench for seq_alu at WIDTH=16
module tb_seq_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   salu = '0;
    logic         in_ready, out_valid, out_err;
    logic [W-1:0] aout;
    logic [3:0]   fout;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .salu      (salu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aout      (aout),
        .fout      (fout),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        in_valid = 1'b1;
        salu = op;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_l, input logic [W-1:0] exp_a,
                               input logic [3:0] exp_f, input logic exp_e);
        int lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_l);
        check({tag, " aout"}, aout, exp_a);
        check({tag, " fout"}, fout, exp_f);
        check({tag, " err"}, out_err, exp_e);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid after take"}, out_valid, 1'b0);
        check({tag, " in_ready after take"}, in_ready, 1'b1);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int exp_l, input logic [W-1:0] exp_a, input logic [3:0] exp_f, input logic exp_e);
        issue(op, av, bv);
        wait_result(tag, exp_l, exp_a, exp_f, exp_e);
        consume(tag);
    endtask

    initial begin
        #1;
        check("reset out_valid", out_valid, 1'b0);
        check("reset aout", aout, 16'h0000);
        check("reset fout", fout, 4'b0000);
        check("reset out_err", out_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", in_ready, 1'b1);

        run("ADD ovf",   4'b0000, 16'd40000, 16'd40000, 1,  16'd14464, 4'b0011, 1'b0);
        run("ADD zero",  4'b0000, 16'd30000, 16'd35536, 1,  16'd0,     4'b0110, 1'b0);
        run("SUB neg",   4'b0001, 16'd34,    16'd35,    1,  16'd65535, 4'b1010, 1'b0);
        run("SUB zero",  4'b0001, 16'd9999,  16'd9999,  1,  16'd0,     4'b0100, 1'b0);
        run("AND",       4'b0010, 16'hF0F0,  16'h0FF0,  1,  16'h00F0,  4'b0000, 1'b0);
        run("OR",        4'b0011, 16'hF000,  16'h000F,  1,  16'hF00F,  4'b1000, 1'b0);
        run("XOR",       4'b0100, 16'hFFFF,  16'hFFFF,  1,  16'h0000,  4'b0100, 1'b0);
        run("SRA 4",     4'b1011, 16'hFF00,  16'd4,     4,  16'hFFF0,  4'b1000, 1'b0);
        run("SRA 20",    4'b1011, 16'h8000,  16'd20,    16, 16'hFFFF,  4'b1010, 1'b0);
        run("SRL 9",     4'b1010, 16'hFF00,  16'd9,     9,  16'h007F,  4'b0010, 1'b0);
        run("SLL 20",    4'b1000, 16'h00FF,  16'd20,    16, 16'h0000,  4'b0110, 1'b0);
        run("SLL 1",     4'b1000, 16'h4001,  16'd1,     1,  16'h8002,  4'b1000, 1'b0);
        run("SLL 0",     4'b1000, 16'h8001,  16'd0,     1,  16'h8001,  4'b1000, 1'b0);
        run("SLR 4",     4'b1001, 16'hFF00,  16'd4,     4,  16'hF00F,  4'b1010, 1'b0);
        run("SLR 16",    4'b1001, 16'hFF00,  16'd16,    1,  16'hFF00,  4'b1000, 1'b0);
        run("MUL small", 4'b0101, 16'd123,   16'd45,    16, 16'd5535,  4'b0000, 1'b0);

        issue(4'b0101, 16'd300, 16'd300);
        wait_result("MUL hold", 16, 16'd24464, 4'b0011, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            salu = 4'b0000;
            a = 16'd1;
            b = 16'd1;
            @(posedge clk);
            #1;
            check("hold out_valid", out_valid, 1'b1);
            check("hold in_ready", in_ready, 1'b0);
            check("hold aout", aout, 16'd24464);
            check("hold fout", fout, 4'b0011);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume("MUL hold");
        @(posedge clk);
        #1;
        check("ignored op not run", out_valid, 1'b0);

        issue(4'b0101, 16'd300, 16'd300);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset aout", aout, 16'h0000);
        check("midreset in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post reset fout", fout, 4'b0000);
        check("post reset err", out_err, 1'b0);
        check("post reset in_ready", in_ready, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("aborted no result", out_valid, 1'b0);

        run("ILLEGAL", 4'b1111, 16'h1234, 16'h5678, 1, 16'h0000, 4'b0100, 1'b1);
        run("ILLEGAL 0110", 4'b0110, 16'h1234, 16'h5678, 1, 16'h0000, 4'b0100, 1'b1);
        run("ADD after illegal", 4'b0000, 16'd1, 16'd2, 1, 16'd3, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle, parametrised successor to the 16-bit combinational ALU; same opcode map extended with logic ops and an iterative multiply.
- Shifts and multiply run one step per cycle, so area stays small at large WIDTH.
- Sits between the register-read stage and writeback in the core.
- Valid/ready handshake on both sides; result and flags stay registered until consumed.

Parameters:
- WIDTH, 16, operand/result width (>=4, power of two).
- SHW, $clog2(WIDTH)+1, localparam: shift-counter width. Derived, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A / shift source
- b  in  WIDTH  operand B / shift amount
- salu  in  4  opcode
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- aout  out  WIDTH  result
- fout  out  4  flags {S,Z,C,V} (bit3..bit0)
- out_err  out  1  opcode was illegal

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE; aout=0, fout=0, out_valid=0, out_err=0, counters=0. in_ready=1 once rst_n is high.
- Reset mid-operation aborts the operation silently; no result is produced.
- States:
  - IDLE: in_ready=1. Accept on in_valid&in_ready; latch a, b, salu. Single-cycle ops compute and go to DONE. Iterative ops load the counter and go to EXEC; a shift count of 0 goes straight to DONE.
  - EXEC: one step per cycle; counter decrements; enters DONE on the edge where counter reaches 0.
  - DONE: out_valid=1. aout, fout and out_err are stable. On out_ready go to IDLE.
- in_ready is 0 in EXEC and DONE. Inputs are ignored there.
- Latency L (accept edge to out_valid high):
  - 1 for single-cycle and illegal ops
  - max(1,n) for shifts
  - WIDTH for MUL
- out_ready held low keeps DONE indefinitely; outputs must not change.
- Opcodes:
  - 0000 ADD: a+b. C=carry out; V=signed overflow.
  - 0001 SUB: a-b. C=borrow (a<b unsigned); V=signed overflow.
  - 0010 AND, 0011 OR, 0100 XOR: C=V=0.
  - 0101 MUL: low WIDTH bits of unsigned a*b, shift-add one bit of b per cycle. C=V=1 iff the high half is nonzero.
  - 1000 SLL: logical left.
  - 1001 SLR: rotate left.
  - 1010 SRL: logical right.
  - 1011 SRA: arithmetic right.
  - Other opcodes: illegal; see below.
- Shift count n:
  - SLL/SRL/SRA: n = min(b, WIDTH). At n=WIDTH the result is 0 (SRA: all sign bits).
  - SLR: n = b mod WIDTH.
  - Shift C = last bit shifted out (rotate: last bit wrapped); C=0 when n=0. V=0.
- All ops: S = aout[WIDTH-1]; Z = (aout==0). Arithmetic wraps modulo 2^WIDTH.
- Illegal opcode: aout=0, fout=4'b0100, out_err=1, latency 1.
- in_valid asserted together with reset release: not accepted until the first edge with rst_n high.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD … OP_SRA (4-bit)
  - flag bit indices F_S=3, F_Z=2, F_C=1, F_V=0
  - state encoding typedef (IDLE, EXEC, DONE)
- One sub-module, alu_iter_unit, holds the shift/rotate and shift-add multiply datapath plus its step counter.
- seq_alu keeps the FSM, handshake, single-cycle ops and flag generation.

Test Plan (WIDTH=16):
- ADD 40000+40000, out_ready=1 -> aout=14464, fout=0011, out_valid one cycle after accept. ADD 30000+35536 -> aout=0, fout=0110.
- SUB 34-35 -> aout=65535, fout=1010. SUB 9999-9999 -> aout=0, fout=0100.
- SRA 0xFF00, b=4 -> 0xFFF0, fout=1000, L=4. SRL 0xFF00, b=9 -> 0x007F, fout=0010, L=9. SLL b=20 -> 0x0000, fout=0110, L=16.
- SLR 0xFF00, b=4 -> 0xF00F, C=1, L=4. SLR b=16 -> 0xFF00, C=0, L=1.
- MUL 300*300 -> aout=24464, fout=0011, L=16. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, new in_valid ignored.
- Pull rst_n low mid-MUL -> outputs 0 and in_ready=1 immediately after release; opcode 1111 -> aout=0, fout=0100, out_err=1.
